// File: rtl/reg_fifo.sv
// reg_fifo: synchronous FIFO built from a DEPTH x n register array.
// Decouples a producer writing on some cycles from a consumer reading on
// others, and reports occupancy, full/empty status and misuse pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   wr_en, d   write request and data, sampled at rising clk
//   rd_en      read request, sampled at rising clk
//   q          registered read data; holds when no read is accepted
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored words, 0..DEPTH
//   overflow   one-cycle pulse after a rejected write
//   underflow  one-cycle pulse after a rejected read
module reg_fifo #(
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [n-1:0]             d,
  input  logic                     rd_en,
  output logic [n-1:0]             q,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_acc;
  logic          rd_acc;

  // A write into a full FIFO is still accepted when a read frees the slot
  // on the same edge; a read from an empty FIFO is never accepted (no bypass).
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage is deliberately not reset; contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp] <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      q         <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wp <= wp + AW'(1);
      end
      // When full with a simultaneous write, wp == rp: q takes the old word
      // because the memory write above only lands after this edge.
      if (rd_acc) begin
        q  <= mem[rp];
        rp <= rp + AW'(1);
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en && full && !rd_en;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Directed self-checking bench for reg_fifo (n=8, DEPTH=4).
module tb_reg_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] d;
  logic       rd_en;
  logic [7:0] q;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  reg_fifo #(.n(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .d         (d),
    .rd_en     (rd_en),
    .q         (q),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one request set, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] din, input logic r);
    wr_en = w;
    d     = din;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    d     = 8'h00;
  endtask

  task automatic check_status(input string tag, input logic [2:0] c,
                              input logic f, input logic e);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_full"},  32'(full),  32'(f));
    check({tag, "_empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    d     = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_status("post_reset", 3'd0, 1'b0, 1'b1);
    check("post_reset_q", 32'(q), 32'h00);

    // Get q nonzero and a word stored, then reset asynchronously mid-cycle.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h6B, 1'b1);
    check("pre_async_q", 32'(q), 32'h5A);
    check("pre_async_count", 32'(count), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_q", 32'(q), 32'h00);
    check_status("async", 3'd0, 1'b0, 1'b1);
    check("async_ovf", 32'(overflow), 32'd0);
    check("async_unf", 32'(underflow), 32'd0);
    #2;
    rst = 1'b0;

    // Fill.
    step(1'b1, 8'h11, 1'b0);  check_status("fill1", 3'd1, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0);  check_status("fill2", 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0);  check_status("fill3", 3'd3, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0);  check_status("fill4", 3'd4, 1'b1, 1'b0);

    // Overflow: rejected write, pulse for exactly one cycle.
    step(1'b1, 8'h55, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check_status("ovf", 3'd4, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full with simultaneous read+write: oldest out, 0xAA stored, no overflow.
    step(1'b1, 8'hAA, 1'b1);
    check("full_rw_q", 32'(q), 32'h11);
    check_status("full_rw", 3'd4, 1'b1, 1'b0);
    check("full_rw_ovf", 32'(overflow), 32'd0);

    // Drain: 0x55 must never appear.
    step(1'b0, 8'h00, 1'b1);  check("drain1", 32'(q), 32'h22);
    step(1'b0, 8'h00, 1'b1);  check("drain2", 32'(q), 32'h33);
    step(1'b0, 8'h00, 1'b1);  check("drain3", 32'(q), 32'h44);
    step(1'b0, 8'h00, 1'b1);  check("drain4", 32'(q), 32'hAA);
    check_status("drained", 3'd0, 1'b0, 1'b1);

    // Underflow, repeated on consecutive cycles, q held.
    step(1'b0, 8'h00, 1'b1);
    check("unf1", 32'(underflow), 32'd1);
    check("unf1_q", 32'(q), 32'hAA);
    step(1'b0, 8'h00, 1'b1);
    check("unf2", 32'(underflow), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("unf_clear", 32'(underflow), 32'd0);
    check("unf_count", 32'(count), 32'd0);

    // Empty with simultaneous read+write: write only, underflow pulses.
    step(1'b1, 8'h77, 1'b1);
    check("empty_rw_unf", 32'(underflow), 32'd1);
    check("empty_rw_q", 32'(q), 32'hAA);
    check_status("empty_rw", 3'd1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("empty_rw_read", 32'(q), 32'h77);
    check("empty_rw_unf_clear", 32'(underflow), 32'd0);
    check_status("empty_rw_done", 3'd0, 1'b0, 1'b1);

    // Wrap-around streaming at occupancy 2.
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hE1, 1'b0);
    check("stream_pre_count", 32'(count), 32'd2);
    step(1'b1, 8'h00, 1'b1);  check("stream0", 32'(q), 32'hE0);
    step(1'b1, 8'h01, 1'b1);  check("stream1", 32'(q), 32'hE1);
    for (int i = 2; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b1);
      check($sformatf("stream%0d", i), 32'(q), 32'(i - 2));
      check($sformatf("stream%0d_count", i), 32'(count), 32'd2);
    end
    step(1'b0, 8'h00, 1'b1);  check("stream_tail8", 32'(q), 32'h08);
    step(1'b0, 8'h00, 1'b1);  check("stream_tail9", 32'(q), 32'h09);
    check_status("stream_done", 3'd0, 1'b0, 1'b1);

    // Reset mid-operation with three words stored.
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    check("mid_pre_count", 32'(count), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check_status("mid_reset", 3'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    step(1'b1, 8'hC3, 1'b0);
    check("after_reset_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("after_reset_q", 32'(q), 32'hC3);
    check("after_reset_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
